counter_ctrl_arb: RTL and testbench

Controller and round-robin arbiter that shares one up/down counter (load, ce, up_down, max_count/zero flags) between two requesters, A and B. Each requester issues a command: LOAD, UP by N steps, DOWN by N steps, or NOP. The block sequences the counter's control pins to execute the command and returns the final count and a status. It sits directly in front of the counter instance, which is instantiated beside it, and owns all of the counter's control inputs.

---
 rtl/ctrl_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/counter_ctrl_arb.sv | 127 ++++++++++++
 tb/tb_counter_ctrl_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the counter controller/arbiter.
// Command encodings, FSM states and response status codes.
package ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic ST_OK    = 1'b0;
    localparam logic ST_BOUND = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
// The requester not granted last wins a tie; history moves only on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_b;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_b ? 2'b01 : 2'b10;
        end
    end

    // Starting with B as last grant lets A win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (accept && (gnt != 2'b00)) begin
            last_b <= gnt[1];
        end
    end

endmodule

// File: rtl/counter_ctrl_arb.sv
// Sequences a shared up/down counter on behalf of two requesters.
// Commands are arbitrated in IDLE and executed one at a time; the result returns on a one-cycle pulse.
module counter_ctrl_arb
    import ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [1:0]        a_op,
    input  logic [WIDTH-1:0]  a_data,
    input  logic [STEP_W-1:0] a_steps,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_op,
    input  logic [WIDTH-1:0]  b_data,
    input  logic [STEP_W-1:0] b_steps,
    output logic              a_rsp_valid,
    output logic              b_rsp_valid,
    output logic [WIDTH-1:0]  rsp_count,
    output logic              rsp_status,
    output logic              cnt_rst_n,
    output logic              cnt_load_n,
    output logic              cnt_up_down,
    output logic              cnt_ce,
    output logic [WIDTH-1:0]  cnt_data_load,
    input  logic [WIDTH-1:0]  cnt_count_out,
    input  logic              cnt_max_count,
    input  logic              cnt_zero
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(1);

    state_e            state;
    op_e               op_q;
    logic [WIDTH-1:0]  data_q;
    logic [STEP_W-1:0] remaining;
    logic              owner_q;
    logic              status_q;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    op_e               sel_op;
    logic [WIDTH-1:0]  sel_data;
    logic [STEP_W-1:0] sel_steps;
    logic              bound;

    // Requests are only offered to the arbiter while idle, so ready is low elsewhere.
    assign req    = (state == IDLE && !rst) ? {b_valid, a_valid} : 2'b00;
    assign accept = |gnt;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    assign a_ready   = gnt[0];
    assign b_ready   = gnt[1];
    assign sel_op    = gnt[1] ? op_e'(b_op) : op_e'(a_op);
    assign sel_data  = gnt[1] ? b_data : a_data;
    assign sel_steps = gnt[1] ? b_steps : a_steps;

    // Bound is judged on the value before the edge, so the counter never wraps.
    assign bound = ((op_q == OP_UP) && cnt_max_count) || ((op_q == OP_DOWN) && cnt_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_NOP;
            data_q    <= '0;
            remaining <= '0;
            owner_q   <= 1'b0;
            status_q  <= ST_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= sel_op;
                        data_q    <= sel_data;
                        remaining <= sel_steps;
                        owner_q   <= gnt[1];
                        status_q  <= ST_OK;
                        if (sel_op == OP_LOAD) begin
                            state <= LOAD;
                        end else if (sel_op == OP_NOP || sel_steps == '0) begin
                            state <= DONE;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                LOAD: state <= DONE;
                STEP: begin
                    if (bound) begin
                        status_q <= ST_BOUND;
                        state    <= DONE;
                    end else begin
                        remaining <= remaining - LAST_STEP;
                        if (remaining == LAST_STEP) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    assign cnt_rst_n     = ~rst;
    assign cnt_load_n    = (state != LOAD);
    assign cnt_data_load = (state == LOAD) ? data_q : '0;
    assign cnt_up_down   = (state == STEP) ? (op_q == OP_UP) : 1'b1;
    assign cnt_ce        = (state == STEP) && !bound;

    assign a_rsp_valid = (state == DONE) && !owner_q;
    assign b_rsp_valid = (state == DONE) && owner_q;
    assign rsp_count   = (state == DONE) ? cnt_count_out : '0;
    assign rsp_status  = (state == DONE) ? status_q : ST_OK;

endmodule

// File: tb/tb_counter_ctrl_arb.sv
// Self-checking bench for counter_ctrl_arb with a behavioural counter beside it.
// Responses are checked against a scoreboard filled from a small reference model.
module tb_counter_ctrl_arb;
    import ctrl_pkg::*;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              a_valid = 1'b0, b_valid = 1'b0;
    logic              a_ready, b_ready;
    logic [1:0]        a_op = 2'b00, b_op = 2'b00;
    logic [WIDTH-1:0]  a_data = '0, b_data = '0;
    logic [STEP_W-1:0] a_steps = '0, b_steps = '0;
    logic              a_rsp_valid, b_rsp_valid;
    logic [WIDTH-1:0]  rsp_count;
    logic              rsp_status;
    logic              cnt_rst_n, cnt_load_n, cnt_up_down, cnt_ce;
    logic [WIDTH-1:0]  cnt_data_load;
    logic [WIDTH-1:0]  cnt_q = '0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             owner;
        logic [WIDTH-1:0] count;
        logic             status;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] model_cnt = '0;

    always #5 clk = ~clk;

    counter_ctrl_arb #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_op          (a_op),
        .a_data        (a_data),
        .a_steps       (a_steps),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_op          (b_op),
        .b_data        (b_data),
        .b_steps       (b_steps),
        .a_rsp_valid   (a_rsp_valid),
        .b_rsp_valid   (b_rsp_valid),
        .rsp_count     (rsp_count),
        .rsp_status    (rsp_status),
        .cnt_rst_n     (cnt_rst_n),
        .cnt_load_n    (cnt_load_n),
        .cnt_up_down   (cnt_up_down),
        .cnt_ce        (cnt_ce),
        .cnt_data_load (cnt_data_load),
        .cnt_count_out (cnt_q),
        .cnt_max_count (&cnt_q),
        .cnt_zero      (cnt_q == '0)
    );

    // Plain wrapping counter: any wrap would expose a controller bug.
    always @(posedge clk) begin
        if (!cnt_rst_n)       cnt_q <= '0;
        else if (!cnt_load_n) cnt_q <= cnt_data_load;
        else if (cnt_ce)      cnt_q <= cnt_up_down ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end

    always @(negedge clk) begin
        if (a_rsp_valid || b_rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_rsp: got a=%0b b=%0b count=%h, expected no response",
                         a_rsp_valid, b_rsp_valid, rsp_count);
            end else begin
                mon_e = sb.pop_front();
                if ({b_rsp_valid, a_rsp_valid} !== (mon_e.owner ? 2'b10 : 2'b01) ||
                    rsp_count !== mon_e.count || rsp_status !== mon_e.status) begin
                    failures++;
                    $display("[TB] FAIL rsp: got b/a=%b count=%h status=%b, expected owner=%0b count=%h status=%b",
                             {b_rsp_valid, a_rsp_valid}, rsp_count, rsp_status,
                             mon_e.owner, mon_e.count, mon_e.status);
                end
            end
        end
    end

    task automatic model_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                             input logic [STEP_W-1:0] steps,
                             output int lat, output int ce_n, output logic st);
        int rem;
        lat = 1; ce_n = 0; st = 1'b0;
        if (op == OP_LOAD) begin
            model_cnt = data;
            lat = 2;
        end else if (op != OP_NOP && steps != 0) begin
            rem = int'(steps);
            while (rem > 0) begin
                if ((op == OP_UP && model_cnt == 4'hF) || (op == OP_DOWN && model_cnt == 4'h0)) begin
                    st = 1'b1;
                    break;
                end
                model_cnt = (op == OP_UP) ? model_cnt + 4'd1 : model_cnt - 4'd1;
                ce_n++;
                rem--;
            end
            lat = ce_n + 1 + int'(st);
        end
    endtask

    task automatic send(input logic who, input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input logic [STEP_W-1:0] steps);
        bit ok = 0;
        if (who) begin b_op = op; b_data = data; b_steps = steps; b_valid = 1'b1; end
        else     begin a_op = op; a_data = data; a_steps = steps; a_valid = 1'b1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (who ? b_ready : a_ready) begin ok = 1; break; end
            @(posedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL handshake_timeout: ready=0 after 20 cycles, expected ready=1");
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int ce_n, output int load_cyc);
        lat = -1; ce_n = 0; load_cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cnt_ce) ce_n++;
            if (!cnt_load_n && load_cyc < 0) load_cyc = k;
            if (a_rsp_valid || b_rsp_valid) begin lat = k; break; end
            @(posedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic exec(input logic who, input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input logic [STEP_W-1:0] steps,
                        output int got_lat, output int got_ce, output int got_load);
        int   m_lat, m_ce;
        logic st;
        model_cmd(op, data, steps, m_lat, m_ce, st);
        sb.push_back('{who, model_cnt, st});
        send(who, op, data, steps);
        wait_rsp(got_lat, got_ce, got_load);
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_ready, b_ready, a_rsp_valid, b_rsp_valid, cnt_ce, cnt_load_n, cnt_up_down, cnt_rst_n, rsp_status} !== 9'b000001100) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 000001100",
                     {a_ready, b_ready, a_rsp_valid, b_rsp_valid, cnt_ce, cnt_load_n, cnt_up_down, cnt_rst_n, rsp_status});
        end
        checks++;
        if (cnt_data_load !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_data_load: got %h, expected 0", cnt_data_load);
        end
        checks++;
        if (rsp_count !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_rsp_count: got %h, expected 0", rsp_count);
        end
        rst = 1'b0;
        model_cnt = '0;
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int lat, ce_n, ld;
        exec(1'b0, OP_LOAD, 4'hA, 8'd0, lat, ce_n, ld);
        checks++;
        if (ld !== 1) begin failures++; $display("[TB] FAIL load_cycle: got %0d, expected 1", ld); end
        checks++;
        if (lat !== 2) begin failures++; $display("[TB] FAIL load_latency: got %0d, expected 2", lat); end
        checks++;
        if (ce_n !== 0) begin failures++; $display("[TB] FAIL load_ce: got %0d, expected 0", ce_n); end
    endtask

    task automatic test_up();
        int lat, ce_n, ld;
        exec(1'b0, OP_UP, 4'h0, 8'd3, lat, ce_n, ld);
        checks++;
        if (ce_n !== 3) begin failures++; $display("[TB] FAIL up_ce: got %0d, expected 3", ce_n); end
        checks++;
        if (lat !== 4) begin failures++; $display("[TB] FAIL up_latency: got %0d, expected 4", lat); end
    endtask

    task automatic test_saturate();
        int lat, ce_n, ld;
        exec(1'b0, OP_LOAD, 4'hE, 8'd0, lat, ce_n, ld);
        exec(1'b0, OP_UP, 4'h0, 8'd5, lat, ce_n, ld);
        checks++;
        if (ce_n !== 1) begin failures++; $display("[TB] FAIL sat_ce: got %0d, expected 1", ce_n); end
        checks++;
        if (lat !== 3) begin failures++; $display("[TB] FAIL sat_latency: got %0d, expected 3", lat); end
    endtask

    task automatic test_floor();
        int lat, ce_n, ld;
        exec(1'b1, OP_LOAD, 4'h1, 8'd0, lat, ce_n, ld);
        exec(1'b1, OP_DOWN, 4'h0, 8'd3, lat, ce_n, ld);
        checks++;
        if (ce_n !== 1) begin failures++; $display("[TB] FAIL floor_ce: got %0d, expected 1", ce_n); end
        checks++;
        if (lat !== 3) begin failures++; $display("[TB] FAIL floor_latency: got %0d, expected 3", lat); end
        exec(1'b1, OP_LOAD, 4'h0, 8'd0, lat, ce_n, ld);
        exec(1'b1, OP_DOWN, 4'h0, 8'd2, lat, ce_n, ld);
        checks++;
        if (ce_n !== 0) begin failures++; $display("[TB] FAIL floor0_ce: got %0d, expected 0", ce_n); end
        checks++;
        if (lat !== 2) begin failures++; $display("[TB] FAIL floor0_latency: got %0d, expected 2", lat); end
    endtask

    task automatic test_round_robin();
        int       grants = 0;
        int       both = 0;
        logic [2:0] order = 3'b000;
        test_reset();
        a_op = OP_NOP; b_op = OP_NOP; a_steps = '0; b_steps = '0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 30 && grants < 3; i++) begin
            @(negedge clk);
            if (a_ready && b_ready) both++;
            if (a_ready || b_ready) begin
                order[grants] = b_ready;
                grants++;
                sb.push_back('{b_ready, model_cnt, ST_OK});
            end
            @(posedge clk); #1;
            if (grants == 3) begin a_valid = 1'b0; b_valid = 1'b0; end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (grants !== 3) begin failures++; $display("[TB] FAIL rr_count: got %0d grants, expected 3", grants); end
        checks++;
        if (order !== 3'b010) begin failures++; $display("[TB] FAIL rr_order: got %b (bit0 first, 1=B), expected 010", order); end
        checks++;
        if (both !== 0) begin failures++; $display("[TB] FAIL rr_both_ready: got %0d cycles, expected 0", both); end
    endtask

    task automatic test_reset_mid_op();
        int lat, ce_n, ld;
        send(1'b0, OP_UP, 4'h0, 8'd10);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt_ce !== 1'b1) begin failures++; $display("[TB] FAIL mid_ce_before: got %b, expected 1", cnt_ce); end
        @(negedge clk);
        checks++;
        if ({cnt_ce, a_rsp_valid, b_rsp_valid, cnt_rst_n, cnt_load_n} !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL mid_reset_ctrl: got ce/arsp/brsp/rst_n/load_n=%b, expected 00001",
                     {cnt_ce, a_rsp_valid, b_rsp_valid, cnt_rst_n, cnt_load_n});
        end
        checks++;
        if (cnt_q !== 4'h0) begin failures++; $display("[TB] FAIL mid_reset_count: got %h, expected 0", cnt_q); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        exec(1'b0, OP_LOAD, 4'h7, 8'd0, lat, ce_n, ld);
        checks++;
        if (lat !== 2) begin failures++; $display("[TB] FAIL post_reset_load_latency: got %0d, expected 2", lat); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_up();
        test_saturate();
        test_floor();
        test_round_robin();
        test_reset_mid_op();
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() !== 0) begin failures++; $display("[TB] FAIL scoreboard_left: got %0d pending, expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at 200000, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
